pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, number of pipeline stages (0=IF … NSTAGE-1=WB), legal range 3..8.
REQ-002 SHALL have parameter AW, default 32, redirect address width.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port stall_req  in  NSTAGE  per-stage hold request (data hazard, multi-cycle unit busy).
REQ-006 SHALL have port flush_req  in  NSTAGE  per-stage redirect request (branch, jump, trap).
REQ-007 SHALL have port flush_addr  in  NSTAGE*AW  redirect targets; stage k occupies bits [k*AW +: AW].
REQ-008 SHALL have port pc_ready  in  1  PC/fetch unit accepts a redirect this cycle.
REQ-009 SHALL have port branch_flag  out  1  redirect valid to PC.
REQ-010 SHALL have port branch_address  out  AW  redirect target.
REQ-011 SHALL have port stop  out  NSTAGE  stop[0] holds PC; stop[i] holds the register feeding stage i.
REQ-012 SHALL have port rst  out  NSTAGE  rst[i] clears the register feeding stage i to a bubble; rst[0] always 0.

Function
REQ-013 SHALL compute f = highest index with flush_req set and s = highest index with stall_req set; the higher index is the older instruction.
REQ-014 SHALL, when a flush exists and (no stall or f > s), assert rst[1..f], deassert all stop, and issue redirect to flush_addr[f]; the stall is discarded.
REQ-015 SHALL, when a stall exists and (no flush or s >= f), assert stop[0..s], assert rst[s+1] if s+1 < NSTAGE, and issue no new redirect (the held flush re-requests later).
REQ-016 SHALL, with neither request, drive all stop and rst to 0.
REQ-017 SHALL issue redirects through a two-state FSM IDLE/PEND.
REQ-018 SHALL, in IDLE, drive branch_flag=1 combinationally with the new target when a redirect issues; if pc_ready=0 the target SHALL be latched and the FSM SHALL move to PEND.
REQ-019 SHALL, in PEND, hold branch_flag=1 with the latched address, assert stop[0] and rst[1], and return to IDLE on the cycle pc_ready=1.
REQ-020 SHALL, on a new flush issuing in PEND, override the latched target (new target driven and latched; FSM stays PEND unless pc_ready=1).
REQ-021 SHALL drive branch_address=PC_INITIAL whenever branch_flag=0.
REQ-022 SHALL keep all stop/rst/branch outputs combinational from inputs and FSM state, with zero-cycle latency.

Reset
REQ-023 SHALL, while reset=1, drive rst[1..NSTAGE-1]=1, stop=0, branch_flag=0, branch_address=PC_INITIAL, regardless of other inputs.
REQ-024 SHALL, on a clock edge with reset=1, set the FSM to IDLE and clear the latched target and all counters; a pending redirect is dropped.

Configuration
REQ-025 SHALL, with PIPE_CTRL_PERF_EN defined, add outputs perf_stall_cnt, perf_flush_cnt, perf_pend_cnt (32 bits each), incrementing once per cycle of REQ-015, REQ-014 and PEND respectively, and saturating at all-ones.
REQ-026 SHALL, without PIPE_CTRL_PERF_EN, omit these ports and counters, and SHALL have otherwise identical behaviour.

Structure
REQ-027 SHALL take ENABLE, DISABLE and PC_INITIAL from the shared ctrl_encode_def.vh definitions, and SHALL add the FSM state encodings PCTL_IDLE/PCTL_PEND there.
REQ-028 SHALL implement f and s with one instantiated sub-module prio_enc (parametrised width, outputs a valid flag and the highest set index), used twice.

Verification (NSTAGE=5, AW=32)
REQ-029 SHALL verify: stall_req=00010 (ID), no flush -> stop=00011, rst=00100, branch_flag=0.
REQ-030 SHALL verify: flush_req=00100 (EX), flush_addr[2]=0x80, stall_req=00010, pc_ready=1 -> rst=00110, stop=0, branch_flag=1, branch_address=0x80.
REQ-031 SHALL verify: flush_req=00010 with stall_req=01000 -> stop=01111, rst=10000, branch_flag=0.
REQ-032 SHALL verify: EX flush to 0x100 with pc_ready=0 for 3 cycles -> branch_flag=1 and address 0x100 held for 4 cycles, stop[0]=rst[1]=1 in PEND, IDLE after pc_ready=1.
REQ-033 SHALL verify: in PEND (target 0x100), MEM flush to 0x200 -> branch_address=0x200 on the same cycle; 0x100 is never re-issued.
REQ-034 SHALL verify: reset asserted in PEND -> rst=11110, branch_flag=0 during reset, and IDLE with no redirect after reset deasserts; with PIPE_CTRL_PERF_EN, counters read 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared control encodings for the pipeline controller: enable levels, the
// PC reset vector and the redirect FSM state encoding.
package pipe_ctrl_pkg;

  localparam logic        ENABLE     = 1'b1;
  localparam logic        DISABLE    = 1'b0;
  localparam logic [31:0] PC_INITIAL = 32'hBFC0_0000;

  typedef enum logic {
    PCTL_IDLE = 1'b0,
    PCTL_PEND = 1'b1
  } pctl_state_e;

endpackage

// File: rtl/pipe_ctrl_prio_enc.sv
// Priority encoder: reports whether any request bit is set and the index of
// the highest set bit (the oldest pipeline stage asking).
module prio_enc #(
  parameter int W  = 5,
  parameter int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  req,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Ascending scan so the last (highest) set bit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < W; i++) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: arbitrates per-stage stall/flush requests and
// issues PC redirects through an IDLE/PEND handshake. Optional performance
// counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int AW     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSTAGE-1:0]    stall_req,
  input  logic [NSTAGE-1:0]    flush_req,
  input  logic [NSTAGE*AW-1:0] flush_addr,
  input  logic                 pc_ready,
  output logic                 branch_flag,
  output logic [AW-1:0]        branch_address,
  output logic [NSTAGE-1:0]    stop,
  output logic [NSTAGE-1:0]    rst
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt,
  output logic [31:0]          perf_flush_cnt,
  output logic [31:0]          perf_pend_cnt
`endif
);

  localparam int IW = $clog2(NSTAGE);
  localparam logic [AW-1:0] PC_INIT = AW'(PC_INITIAL);

  logic          f_valid;
  logic          s_valid;
  logic [IW-1:0] f_idx;
  logic [IW-1:0] s_idx;
  logic          do_flush;
  logic          do_stall;
  logic [AW-1:0] new_addr;

  pctl_state_e   state;
  pctl_state_e   next_state;
  logic [AW-1:0] pend_addr;
  logic [AW-1:0] next_addr;

  prio_enc #(.W(NSTAGE), .IW(IW)) u_flush_enc (
    .req   (flush_req),
    .valid (f_valid),
    .idx   (f_idx)
  );

  prio_enc #(.W(NSTAGE), .IW(IW)) u_stall_enc (
    .req   (stall_req),
    .valid (s_valid),
    .idx   (s_idx)
  );

  // An older (higher-index) flush kills any younger stall; a stall at the
  // same or older stage holds the flushing instruction so it re-requests later.
  assign do_flush = f_valid && (!s_valid || (f_idx > s_idx));
  assign do_stall = s_valid && !do_flush;
  assign new_addr = flush_addr[f_idx*AW +: AW];

  always_comb begin
    stop           = '0;
    rst            = '0;
    branch_flag    = DISABLE;
    branch_address = PC_INIT;
    next_state     = state;
    next_addr      = pend_addr;

    if (do_flush) begin
      for (int i = 1; i < NSTAGE; i++) begin
        rst[i] = (i <= int'(f_idx));
      end
      branch_flag    = ENABLE;
      branch_address = new_addr;
      next_addr      = new_addr;
      next_state     = pc_ready ? PCTL_IDLE : PCTL_PEND;
    end else begin
      if (do_stall) begin
        for (int i = 0; i < NSTAGE; i++) begin
          stop[i] = (i <= int'(s_idx));
          rst[i]  = (i == int'(s_idx) + 1);
        end
      end
      // Waiting for fetch: keep the PC frozen and feed bubbles into stage 1.
      if (state == PCTL_PEND) begin
        branch_flag    = ENABLE;
        branch_address = pend_addr;
        stop[0]        = ENABLE;
        rst[1]         = ENABLE;
        if (pc_ready) begin
          next_state = PCTL_IDLE;
        end
      end
    end

    if (reset) begin
      stop           = '0;
      rst            = {{(NSTAGE-1){1'b1}}, 1'b0};
      branch_flag    = DISABLE;
      branch_address = PC_INIT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PCTL_IDLE;
      pend_addr <= '0;
    end else begin
      state     <= next_state;
      pend_addr <= next_addr;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating event counters; they stick at all-ones rather than wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
      perf_pend_cnt  <= '0;
    end else begin
      if (do_stall && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (do_flush && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      end
      if ((state == PCTL_PEND) && (perf_pend_cnt != '1)) begin
        perf_pend_cnt <= perf_pend_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (NSTAGE=5, AW=32); expected
// values are hand-computed per step.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic         clk;
  logic         reset;
  logic [4:0]   stall_req;
  logic [4:0]   flush_req;
  logic [159:0] flush_addr;
  logic         pc_ready;
  logic         branch_flag;
  logic [31:0]  branch_address;
  logic [4:0]   stop;
  logic [4:0]   rst;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]  perf_stall_cnt;
  logic [31:0]  perf_flush_cnt;
  logic [31:0]  perf_pend_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_ctrl #(.NSTAGE(5), .AW(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall_req      (stall_req),
    .flush_req      (flush_req),
    .flush_addr     (flush_addr),
    .pc_ready       (pc_ready),
    .branch_flag    (branch_flag),
    .branch_address (branch_address),
    .stop           (stop),
    .rst            (rst)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_pend_cnt  (perf_pend_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input logic rs, input logic [4:0] st,
                               input logic [4:0] fl, input logic rdy);
    @(negedge clk);
    reset     = rs;
    stall_req = st;
    flush_req = fl;
    pc_ready  = rdy;
    #1;
  endtask

  task automatic setTarget(input int k, input logic [31:0] a);
    flush_addr[k*32 +: 32] = a;
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [4:0] e_stop,
                             input logic [4:0] e_rst, input logic e_flag,
                             input logic [31:0] e_addr);
    checkVal({tag, ".stop"}, 32'(stop), 32'(e_stop));
    checkVal({tag, ".rst"}, 32'(rst), 32'(e_rst));
    checkVal({tag, ".flag"}, 32'(branch_flag), 32'(e_flag));
    checkVal({tag, ".addr"}, branch_address, e_addr);
  endtask

  initial begin
    reset      = 1'b1;
    stall_req  = '0;
    flush_req  = '0;
    flush_addr = '0;
    pc_ready   = 1'b1;

    // Reset overrides every request.
    setTarget(4, 32'h0000_0444);
    applyStimulus(1'b1, 5'b11111, 5'b11111, 1'b1);
    checkOutput("reset_override", 5'b00000, 5'b11110, 1'b0, PC_INITIAL);
    applyStimulus(1'b1, 5'b00000, 5'b00000, 1'b1);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b1);
    checkOutput("idle", 5'b00000, 5'b00000, 1'b0, PC_INITIAL);

    applyStimulus(1'b0, 5'b00010, 5'b00000, 1'b1);
    checkOutput("stall_id", 5'b00011, 5'b00100, 1'b0, PC_INITIAL);

    applyStimulus(1'b0, 5'b10000, 5'b00000, 1'b1);
    checkOutput("stall_wb", 5'b11111, 5'b00000, 1'b0, PC_INITIAL);

    setTarget(2, 32'h0000_0080);
    applyStimulus(1'b0, 5'b00010, 5'b00100, 1'b1);
    checkOutput("flush_ex_over_stall", 5'b00000, 5'b00110, 1'b1, 32'h0000_0080);

    applyStimulus(1'b0, 5'b01000, 5'b00010, 1'b1);
    checkOutput("stall_over_flush", 5'b01111, 5'b10000, 1'b0, PC_INITIAL);

    applyStimulus(1'b0, 5'b00100, 5'b00100, 1'b1);
    checkOutput("tie_stall_wins", 5'b00111, 5'b01000, 1'b0, PC_INITIAL);

    applyStimulus(1'b0, 5'b00000, 5'b10000, 1'b1);
    checkOutput("flush_wb", 5'b00000, 5'b11110, 1'b1, 32'h0000_0444);

    // Redirect held in PEND while fetch is busy.
    setTarget(2, 32'h0000_0100);
    applyStimulus(1'b0, 5'b00000, 5'b00100, 1'b0);
    checkOutput("pend_issue", 5'b00000, 5'b00110, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b0);
    checkOutput("pend_hold1", 5'b00001, 5'b00010, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b0);
    checkOutput("pend_hold2", 5'b00001, 5'b00010, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b1);
    checkOutput("pend_accept", 5'b00001, 5'b00010, 1'b1, 32'h0000_0100);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b1);
    checkOutput("pend_done", 5'b00000, 5'b00000, 1'b0, PC_INITIAL);

    // A newer redirect in PEND replaces the latched target.
    applyStimulus(1'b0, 5'b00000, 5'b00100, 1'b0);
    checkOutput("ovr_issue", 5'b00000, 5'b00110, 1'b1, 32'h0000_0100);
    setTarget(3, 32'h0000_0200);
    applyStimulus(1'b0, 5'b00000, 5'b01000, 1'b0);
    checkOutput("ovr_new", 5'b00000, 5'b01110, 1'b1, 32'h0000_0200);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b0);
    checkOutput("ovr_hold", 5'b00001, 5'b00010, 1'b1, 32'h0000_0200);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b1);
    checkOutput("ovr_accept", 5'b00001, 5'b00010, 1'b1, 32'h0000_0200);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b1);
    checkOutput("ovr_done", 5'b00000, 5'b00000, 1'b0, PC_INITIAL);

    // Reset while PEND drops the redirect.
    setTarget(2, 32'h0000_0300);
    applyStimulus(1'b0, 5'b00000, 5'b00100, 1'b0);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b0);
    checkOutput("rp_pend", 5'b00001, 5'b00010, 1'b1, 32'h0000_0300);
    applyStimulus(1'b1, 5'b00000, 5'b00000, 1'b0);
    checkOutput("rp_reset", 5'b00000, 5'b11110, 1'b0, PC_INITIAL);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b0);
    checkOutput("rp_after", 5'b00000, 5'b00000, 1'b0, PC_INITIAL);
`ifdef PIPE_CTRL_PERF_EN
    checkVal("perf_stall_zero", perf_stall_cnt, 32'd0);
    checkVal("perf_flush_zero", perf_flush_cnt, 32'd0);
    checkVal("perf_pend_zero", perf_pend_cnt, 32'd0);
    applyStimulus(1'b0, 5'b00010, 5'b00000, 1'b1);
    applyStimulus(1'b0, 5'b00000, 5'b00000, 1'b1);
    checkVal("perf_stall_one", perf_stall_cnt, 32'd1);
    checkVal("perf_flush_still", perf_flush_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
